// File: rtl/power_pkg.sv
// Shared types and default tuning for the step-down converter.
// Holds the FSM state encoding and default parameter values.
package power_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAMP     = 2'd1,
    ST_REGULATE = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [7:0] DEF_RAMP_STEP = 8'd4;
  localparam logic [7:0] DEF_OV_LIMIT  = 8'd240;
  localparam int         DEF_OV_COUNT  = 3;

endpackage

// File: rtl/ov_detector.sv
// Over-voltage detector: counts consecutive over-limit samples.
// Ports: clk, rst_n, i_vin, i_vin_valid -> o_trip, o_clear (count==0).
module ov_detector
  import power_pkg::*;
#(
  parameter logic [7:0] OV_LIMIT = DEF_OV_LIMIT,
  parameter int         OV_COUNT = DEF_OV_COUNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_vin,
  input  logic       i_vin_valid,
  output logic       o_trip,
  output logic       o_clear
);

  localparam logic [3:0] LP_MAX = OV_COUNT[3:0];

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_over;

  assign w_over = (i_vin > OV_LIMIT);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_vin_valid) begin
      if (!w_over) begin
        w_cnt_nxt = 4'd0;
      end else if (r_cnt != LP_MAX) begin
        w_cnt_nxt = r_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Trip on every over-limit sample that leaves the count at its limit.
  assign o_trip  = i_vin_valid && w_over && (w_cnt_nxt == LP_MAX);
  assign o_clear = (r_cnt == 4'd0);

endmodule

// File: rtl/step_down_converter.sv
// Soft-start step-down converter control with over-voltage latch.
// Ports: clk, rst_n, en, vin, vin_valid -> vout, vout_valid, pgood, fault, state.
module step_down_converter
  import power_pkg::*;
#(
  parameter logic [7:0] RAMP_STEP = DEF_RAMP_STEP,
  parameter logic [7:0] OV_LIMIT  = DEF_OV_LIMIT,
  parameter int         OV_COUNT  = DEF_OV_COUNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] vin,
  input  logic       vin_valid,
  output logic [7:0] vout,
  output logic       vout_valid,
  output logic       pgood,
  output logic       fault,
  output logic [1:0] state
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_vout;
  logic       r_vout_valid;

  logic       w_trip;
  logic       w_clear;
  logic [8:0] w_target;
  logic [8:0] w_sum;
  logic [7:0] w_new;
  logic       w_active;
  logic       w_accept;

  ov_detector #(
    .OV_LIMIT (OV_LIMIT),
    .OV_COUNT (OV_COUNT)
  ) u_ov (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_vin       (vin),
    .i_vin_valid (vin_valid),
    .o_trip      (w_trip),
    .o_clear     (w_clear)
  );

  assign w_target = {2'b00, vin[7:1]};
  assign w_sum    = {1'b0, r_vout} + {1'b0, RAMP_STEP};

  // Downward moves and final approach both land exactly on target.
  assign w_new = (w_sum >= w_target) ? w_target[7:0] : w_sum[7:0];

  assign w_active = (r_state == ST_RAMP) ||
                    (r_state == ST_REGULATE);
  assign w_accept = w_active && vin_valid && en && !w_trip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_trip) begin
      w_state_nxt = ST_FAULT;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (en) w_state_nxt = ST_RAMP;
        end
        ST_RAMP: begin
          if (!en)
            w_state_nxt = ST_IDLE;
          else if (vin_valid && (w_new == w_target[7:0]))
            w_state_nxt = ST_REGULATE;
        end
        ST_REGULATE: begin
          if (!en) w_state_nxt = ST_IDLE;
        end
        ST_FAULT: begin
          if (!en && w_clear) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pgood = 1'b0;
    fault = 1'b0;
    unique case (r_state)
      ST_REGULATE: pgood = 1'b1;
      ST_FAULT:    fault = 1'b1;
      default: begin
        pgood = 1'b0;
        fault = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vout       <= 8'd0;
      r_vout_valid <= 1'b0;
    end else begin
      r_vout_valid <= w_accept;
      if (w_accept) begin
        r_vout <= w_new;
      end else if (w_trip || !en || !w_active) begin
        r_vout <= 8'd0;
      end
    end
  end

  assign vout       = r_vout;
  assign vout_valid = r_vout_valid;
  assign state      = r_state;

endmodule

// File: tb/tb_step_down_converter.sv
// Directed bench for step_down_converter.
// Drives inputs before each edge and checks #1 after it.
module tb_step_down_converter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] vin;
  logic       vin_valid;
  logic [7:0] vout;
  logic       vout_valid;
  logic       pgood;
  logic       fault;
  logic [1:0] state;

  int total;
  int bad;

  step_down_converter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .vin        (vin),
    .vin_valid  (vin_valid),
    .vout       (vout),
    .vout_valid (vout_valid),
    .pgood      (pgood),
    .fault      (fault),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    vin = 8'd250; vin_valid = 1'b1;
    tick(); tick();
    total++;
    if (state !== 2'd0) begin
      bad++; $display("FAIL rst_state: got %0d want 0", state);
    end
    total++;
    if (vout !== 8'd0) begin
      bad++; $display("FAIL rst_vout: got %0d want 0", vout);
    end
    total++;
    if ({vout_valid, pgood, fault} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags: got %b want 000",
               {vout_valid, pgood, fault});
    end
  endtask

  task automatic test_soft_start();
    logic [7:0] ev;
    rst_n = 1'b1; en = 1'b1;
    vin_valid = 1'b0; vin = 8'd100;
    tick();
    chk("ss_enter_ramp", {6'd0, state}, 8'd1);
    chk("ss_no_valid", {7'd0, vout_valid}, 8'd0);
    vin_valid = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      ev = (i < 13) ? 8'(4 * i) : 8'd50;
      chk("ss_vout", vout, ev);
      chk("ss_valid", {7'd0, vout_valid}, 8'd1);
      chk("ss_pgood", {7'd0, pgood},
          (i == 13) ? 8'd1 : 8'd0);
    end
    chk("ss_state", {6'd0, state}, 8'd2);
  endtask

  task automatic test_step();
    logic [7:0] ev;
    vin = 8'd60; vin_valid = 1'b1;
    tick();
    chk("dn_vout", vout, 8'd30);
    chk("dn_state", {6'd0, state}, 8'd2);
    vin = 8'd100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      ev = 8'(30 + 4 * i);
      chk("up_vout", vout, ev);
      chk("up_pgood", {7'd0, pgood}, 8'd1);
    end
    vin_valid = 1'b0;
    tick();
    chk("hold_valid", {7'd0, vout_valid}, 8'd0);
    chk("hold_vout", vout, 8'd50);
  endtask

  task automatic test_ov();
    logic [7:0] seq [6];
    logic [7:0] ev  [6];
    seq = '{8'd250, 8'd250, 8'd100, 8'd250, 8'd250, 8'd250};
    ev  = '{8'd54, 8'd58, 8'd50, 8'd54, 8'd58, 8'd0};
    vin_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vin = seq[i];
      tick();
      chk("ov_vout", vout, ev[i]);
      chk("ov_fault", {7'd0, fault},
          (i == 5) ? 8'd1 : 8'd0);
      chk("ov_state", {6'd0, state},
          (i == 5) ? 8'd3 : 8'd2);
    end
    chk("ov_valid", {7'd0, vout_valid}, 8'd0);
  endtask

  task automatic test_fault_exit();
    vin = 8'd100; vin_valid = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fx_stay", {6'd0, state}, 8'd3);
      chk("fx_pgood", {7'd0, pgood}, 8'd0);
      chk("fx_vout", vout, 8'd0);
    end
    en = 1'b0; vin_valid = 1'b0;
    tick();
    chk("fx_idle", {6'd0, state}, 8'd0);
    chk("fx_clr", {7'd0, fault}, 8'd0);
    en = 1'b1;
    tick();
    chk("fx_ramp", {6'd0, state}, 8'd1);
  endtask

  task automatic test_reset_mid();
    vin = 8'd100; vin_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rm_pre", vout, 8'd24);
    rst_n = 1'b0;
    tick();
    chk("rm_state", {6'd0, state}, 8'd0);
    chk("rm_vout", vout, 8'd0);
    chk("rm_valid", {7'd0, vout_valid}, 8'd0);
    rst_n = 1'b1; vin_valid = 1'b0;
    tick();
    chk("rm_ramp", {6'd0, state}, 8'd1);
    vin = 8'd250; vin_valid = 1'b1;
    tick(); tick();
    chk("rm_vout8", vout, 8'd8);
    tick();
    chk("rm_fault", {7'd0, fault}, 8'd1);
    rst_n = 1'b0;
    tick();
    chk("rf_fault", {7'd0, fault}, 8'd0);
    chk("rf_state", {6'd0, state}, 8'd0);
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b1; en = 1'b1; vin_valid = 1'b0;
    tick();
    vin = 8'd250; vin_valid = 1'b1;
    tick(); tick();
    en = 1'b0;
    tick();
    chk("sim_state", {6'd0, state}, 8'd3);
    chk("sim_vout", vout, 8'd0);
  endtask

  task automatic test_boundary();
    vin = 8'd100; vin_valid = 1'b1; en = 1'b0;
    tick();
    chk("bd_hold_flt", {6'd0, state}, 8'd3);
    vin_valid = 1'b0;
    tick();
    chk("bd_idle", {6'd0, state}, 8'd0);
    en = 1'b1;
    tick();
    vin = 8'd240; vin_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bd_lim_state", {6'd0, state}, 8'd1);
    chk("bd_lim_vout", vout, 8'd16);
    vin = 8'd20;
    tick();
    chk("bd_down_vout", vout, 8'd10);
    chk("bd_down_reg", {6'd0, state}, 8'd2);
    vin = 8'd0;
    tick();
    chk("bd_zero_vout", vout, 8'd0);
    chk("bd_zero_reg", {6'd0, state}, 8'd2);
    vin = 8'd255;
    tick();
    chk("bd_255_vout", vout, 8'd4);
    en = 1'b0;
    tick();
    chk("bd_off_state", {6'd0, state}, 8'd0);
    chk("bd_off_vout", vout, 8'd0);
    chk("bd_off_valid", {7'd0, vout_valid}, 8'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; en = 1'b0;
    vin = 8'd0; vin_valid = 1'b0;
    test_reset();
    test_soft_start();
    test_step();
    test_ov();
    test_fault_exit();
    test_reset_mid();
    test_simultaneous();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
